// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-byte fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam int FETCH_ADDR_W   = 16;
   localparam int FETCH_DEPTH    = 2;
   localparam int FETCH_RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Byte-wide circular prefetch buffer; flush wins over push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_CNT);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   // A push into a full buffer is only accepted when the head leaves the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mem_q[gi] <= '0;
         end else begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, memory read handshake and prefetch buffer feeding the
// control unit's instruction-register load path.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DEPTH    = FETCH_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pcc,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [7:0]        ir_data,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_req_q, mem_req_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     occ_after;
   logic [7:0]        fifo_rdata;

   // A redirect kills both the same-cycle pop and the same-cycle returned byte.
   assign fifo_pop  = pcc & ~fifo_empty & ~jump;
   assign fifo_push = (state_q == BUSY) & mem_ack & ~jump;
   assign occ_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (jump),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (mem_rdata),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;

      if (jump) begin
         pc_d         = jump_addr;
         fetch_addr_d = jump_addr;
      end else begin
         if (fifo_pop)  pc_d         = pc_q + 1'b1;
         if (fifo_push) fetch_addr_d = fetch_addr_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (jump || ~fifo_full || fifo_pop) begin
               state_d    = BUSY;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr_d;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               if (jump || (occ_after < DEPTH_CNT)) begin
                  mem_addr_d = fetch_addr_d;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end else if (jump) begin
               // The outstanding read cannot be withdrawn; wait it out and drop it.
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (mem_ack) begin
               state_d    = BUSY;
               mem_addr_d = fetch_addr_d;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign pc       = pc_q;
   assign ir_data  = fifo_rdata;
   assign ir_valid = ~fifo_empty;
   assign stall    = pcc & ~ir_valid;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench: behavioural memory with random latency and a byte-stream
// reference model of what the control unit should see.
module tb_fetch_unit;

   localparam int AW    = 16;
   localparam int DEPTH = 2;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          pcc       = 1'b0;
   logic          jump      = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic [7:0]    ir_data;
   logic          ir_valid;
   logic [AW-1:0] pc;
   logic          stall;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata = '0;
   logic          mem_ack   = 1'b0;

   int total = 0;
   int bad   = 0;

   // memory model state
   int            lat_min  = 0;
   int            lat_max  = 0;
   int            wcnt     = 0;
   int            cur_lat  = 0;
   bit            new_txn  = 1'b1;
   logic [AW-1:0] req_addr = '0;
   int            unstable = 0;
   logic [AW-1:0] ack_log [$];
   logic [7:0]    key      = '0;

   fetch_unit #(
      .ADDR_W   (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pcc       (pcc),
      .jump      (jump),
      .jump_addr (jump_addr),
      .ir_data   (ir_data),
      .ir_valid  (ir_valid),
      .pc        (pc),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      return a[7:0] ^ key;
   endfunction

   // Program memory: acks each request after cur_lat wait cycles, logs acked
   // addresses, and counts any address change or withdrawal while waiting.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         mem_ack = 1'b0;
         wcnt    = 0;
         new_txn = 1'b1;
      end else if (!mem_req) begin
         if (!mem_ack && !new_txn) unstable++;
         mem_ack = 1'b0;
         wcnt    = 0;
         new_txn = 1'b1;
      end else begin
         if (mem_ack || new_txn) begin
            wcnt     = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
            req_addr = mem_addr;
            new_txn  = 1'b0;
         end else if (mem_addr !== req_addr) begin
            unstable++;
         end
         if (wcnt >= cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_byte(mem_addr);
            ack_log.push_back(mem_addr);
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      pcc   = 1'b0;
      jump  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ack_log.delete();
      unstable = 0;
   endtask

   task automatic test_reset();
      key = 8'hA5; lat_min = 0; lat_max = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++; $display("FAIL reset_first_req_early: mem_req=%b want 0", mem_req);
      end
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         bad++; $display("FAIL reset_first_req: mem_req=%b mem_addr=%h want 1/0000", mem_req, mem_addr);
      end
      pcc = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (pc === 16'h0000) begin
         bad++; $display("FAIL reset_precondition: pc=%h want nonzero before reset", pc);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (pc !== 16'h0000 || ir_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0000 || ir_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_async_values: pc=%h ir_valid=%b mem_req=%b mem_addr=%h ir_data=%h want 0000/0/0/0000/00",
                  pc, ir_valid, mem_req, mem_addr, ir_data);
      end
      total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL reset_stall: stall=%b want 1 (pcc high, buffer empty)", stall);
      end
      pcc = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      ack_log.delete();
      unstable = 0;
   endtask

   task automatic test_zero_wait();
      logic [AW-1:0] exp_pc = '0;
      key = 8'h00; lat_min = 0; lat_max = 0;
      do_reset();
      @(negedge clk);
      total++;
      if (ir_valid !== 1'b0) begin
         bad++; $display("FAIL zw_early_valid: ir_valid=%b want 0", ir_valid);
      end
      @(negedge clk);
      total++;
      if (ir_valid !== 1'b1 || ir_data !== 8'h00) begin
         bad++; $display("FAIL zw_fill_latency: ir_valid=%b ir_data=%h want 1/00", ir_valid, ir_data);
      end
      pcc = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         total++;
         if (ir_valid !== 1'b1 || stall !== 1'b0 || ir_data !== exp_pc[7:0] || pc !== exp_pc) begin
            bad++;
            $display("FAIL zw_stream[%0d]: ir_valid=%b stall=%b ir_data=%h pc=%h want 1/0/%h/%h",
                     i, ir_valid, stall, ir_data, pc, exp_pc[7:0], exp_pc);
         end
         exp_pc++;
         @(negedge clk);
      end
      pcc = 1'b0;
   endtask

   task automatic test_slow_mem();
      logic [AW-1:0] exp_pc = '0;
      int stalls = 0;
      int seq_bad = 0;
      key = 8'($urandom); lat_min = 3; lat_max = 3;
      do_reset();
      pcc = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (ir_valid) begin
            total++;
            if (ir_data !== mem_byte(exp_pc) || pc !== exp_pc || stall !== 1'b0) begin
               bad++;
               $display("FAIL slow_byte: ir_data=%h pc=%h stall=%b want %h/%h/0",
                        ir_data, pc, stall, mem_byte(exp_pc), exp_pc);
            end
            exp_pc++;
         end else begin
            stalls++;
            total++;
            if (stall !== 1'b1) begin
               bad++; $display("FAIL slow_stall: stall=%b want 1 while empty", stall);
            end
         end
         @(negedge clk);
      end
      pcc = 1'b0;
      total++;
      if (exp_pc < 16'd10 || stalls == 0) begin
         bad++; $display("FAIL slow_progress: consumed=%0d stalls=%0d want >=10 and >0", exp_pc, stalls);
      end
      for (int i = 0; i < ack_log.size(); i++) begin
         if (ack_log[i] !== 16'(i)) seq_bad++;
      end
      total++;
      if (seq_bad != 0 || unstable != 0) begin
         bad++; $display("FAIL slow_addr_seq: out_of_order=%0d unstable=%0d want 0/0", seq_bad, unstable);
      end
   endtask

   task automatic test_jump_pending();
      key = 8'h00; lat_min = 4; lat_max = 4;
      do_reset();
      jump = 1'b1; jump_addr = 16'h0005;
      @(negedge clk);
      jump = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || mem_ack !== 1'b0) begin
         bad++; $display("FAIL jp_setup: mem_req=%b mem_addr=%h mem_ack=%b want 1/0005/0", mem_req, mem_addr, mem_ack);
      end
      jump = 1'b1; jump_addr = 16'h1234; pcc = 1'b1;
      @(negedge clk);
      jump = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (ir_valid) break;
         @(negedge clk);
      end
      #1;
      total++;
      if (ir_valid !== 1'b1 || ir_data !== 8'h34 || pc !== 16'h1234) begin
         bad++; $display("FAIL jp_target: ir_valid=%b ir_data=%h pc=%h want 1/34/1234", ir_valid, ir_data, pc);
      end
      total++;
      if (ack_log.size() != 2 || ack_log[0] !== 16'h0005 || ack_log[1] !== 16'h1234 || unstable != 0) begin
         bad++;
         $display("FAIL jp_mem_seq: acks=%0d first=%h second=%h unstable=%0d want 2/0005/1234/0",
                  ack_log.size(), ack_log.size() > 0 ? ack_log[0] : 16'hxxxx,
                  ack_log.size() > 1 ? ack_log[1] : 16'hxxxx, unstable);
      end
      @(negedge clk);
      pcc = 1'b0;
   endtask

   task automatic test_same_cycle();
      logic [AW-1:0] ja;
      key = 8'($urandom); lat_min = 0; lat_max = 0;
      do_reset();
      pcc = 1'b1;
      repeat (4) @(negedge clk);
      ja = 16'($urandom) | 16'h0100;
      total++;
      if (mem_ack !== 1'b1 || ir_valid !== 1'b1) begin
         bad++; $display("FAIL sc_setup: mem_ack=%b ir_valid=%b want 1/1", mem_ack, ir_valid);
      end
      jump = 1'b1; jump_addr = ja; pcc = 1'b1;
      @(negedge clk);
      jump = 1'b0; pcc = 1'b0;
      #1;
      total++;
      if (ir_valid !== 1'b0 || pc !== ja || mem_req !== 1'b1 || mem_addr !== ja) begin
         bad++;
         $display("FAIL sc_flush: ir_valid=%b pc=%h mem_req=%b mem_addr=%h want 0/%h/1/%h",
                  ir_valid, pc, mem_req, mem_addr, ja, ja);
      end
      @(negedge clk);
      total++;
      if (ir_valid !== 1'b1 || ir_data !== mem_byte(ja) || pc !== ja) begin
         bad++;
         $display("FAIL sc_redirect_fill: ir_valid=%b ir_data=%h pc=%h want 1/%h/%h",
                  ir_valid, ir_data, pc, mem_byte(ja), ja);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_pc = 16'hFFFE;
      int got = 0;
      key = 8'($urandom); lat_min = 0; lat_max = 0;
      do_reset();
      jump = 1'b1; jump_addr = 16'hFFFE;
      for (int i = 0; i < 12 && got < 3; i++) begin
         @(negedge clk);
         jump = 1'b0; pcc = 1'b1;
         #1;
         if (ir_valid) begin
            total++;
            if (pc !== exp_pc || ir_data !== mem_byte(exp_pc)) begin
               bad++; $display("FAIL wrap_byte: pc=%h ir_data=%h want %h/%h", pc, ir_data, exp_pc, mem_byte(exp_pc));
            end
            exp_pc++;
            got++;
         end
      end
      @(negedge clk);
      pcc = 1'b0;
      total++;
      if (got != 3) begin
         bad++; $display("FAIL wrap_timeout: consumed=%0d want 3", got);
      end
      total++;
      if (ack_log.size() < 3 || ack_log[0] !== 16'hFFFE || ack_log[1] !== 16'hFFFF || ack_log[2] !== 16'h0000) begin
         bad++;
         $display("FAIL wrap_mem_addr: acks=%0d third=%h want >=3 and FFFE,FFFF,0000",
                  ack_log.size(), ack_log.size() > 2 ? ack_log[2] : 16'hxxxx);
      end
   endtask

   task automatic test_no_pcc();
      key = 8'($urandom); lat_min = 0; lat_max = 0;
      do_reset();
      repeat (10) @(negedge clk);
      total++;
      if (ack_log.size() != DEPTH || mem_req !== 1'b0 || ir_valid !== 1'b1 || ir_data !== mem_byte(16'h0000) || pc !== 16'h0000) begin
         bad++;
         $display("FAIL nopcc_fill: acks=%0d mem_req=%b ir_valid=%b ir_data=%h pc=%h want %0d/0/1/%h/0000",
                  ack_log.size(), mem_req, ir_valid, ir_data, pc, DEPTH, mem_byte(16'h0000));
      end
      pcc = 1'b1;
      @(negedge clk);
      pcc = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (ack_log.size() != DEPTH + 1 || mem_req !== 1'b0 || pc !== 16'h0001 || ir_data !== mem_byte(16'h0001)
          || ack_log[ack_log.size()-1] !== 16'(DEPTH)) begin
         bad++;
         $display("FAIL nopcc_one_refill: acks=%0d mem_req=%b pc=%h ir_data=%h want %0d/0/0001/%h",
                  ack_log.size(), mem_req, pc, ir_data, DEPTH + 1, mem_byte(16'h0001));
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] exp_pc = '0;
      int pops = 0;
      key = 8'($urandom); lat_min = 0; lat_max = 3;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         jump      = ($urandom_range(0, 15) == 0);
         jump_addr = 16'($urandom);
         pcc       = ($urandom_range(0, 3) != 0);
         #1;
         total++;
         if (stall !== (pcc & ~ir_valid)) begin
            bad++; $display("FAIL rnd_stall[%0d]: stall=%b want %b", i, stall, pcc & ~ir_valid);
         end
         if (ir_valid) begin
            total++;
            if (pc !== exp_pc || ir_data !== mem_byte(exp_pc)) begin
               bad++;
               $display("FAIL rnd_byte[%0d]: pc=%h ir_data=%h want %h/%h", i, pc, ir_data, exp_pc, mem_byte(exp_pc));
            end
         end
         if (jump) begin
            exp_pc = jump_addr;
         end else if (pcc && ir_valid) begin
            exp_pc++;
            pops++;
         end
      end
      @(negedge clk);
      jump = 1'b0; pcc = 1'b0;
      total++;
      if (pops < 50 || unstable != 0) begin
         bad++; $display("FAIL rnd_summary: pops=%0d unstable=%0d want >=50/0", pops, unstable);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_slow_mem();
      test_jump_pending();
      test_same_cycle();
      test_wrap();
      test_no_pcc();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-byte supplier for the control unit: holds the program counter, issues byte reads to program memory over a req/ack handshake, and keeps a small prefetch buffer so the control unit can latch a new instruction or operand byte on the cycle it asks for one. It responds to the control unit's `pcc` (advance) strobe and to jump redirects from the datapath. It is the producing end of the control unit's instruction-register load path.

## Interface
- `ADDR_W`, 16: program address width.
- `DEPTH`, 2: prefetch buffer entries (power of two, ≥2).
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pcc`  in  1  consume the head byte and advance PC.
- `jump`  in  1  redirect fetch to `jump_addr`; single-cycle strobe.
- `jump_addr`  in  ADDR_W  redirect target.
- `ir_data`  out  8  head byte of the prefetch buffer.
- `ir_valid`  out  1  `ir_data` is valid.
- `pc`  out  ADDR_W  address of the byte at `ir_data`.
- `stall`  out  1  combinational: `pcc & ~ir_valid`.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.
- `mem_ack`  in  1  single-cycle completion pulse.

## Operation
- Reset values:
  - `pc` = `fetch_addr` = `RESET_PC`.
  - Buffer empty, `ir_valid` = 0.
  - `mem_req` = 0, `mem_addr` = `RESET_PC`, `ir_data` = 0.
  - State IDLE.
- FSM states: IDLE, BUSY, DISCARD.
  - IDLE → BUSY: when occupancy < `DEPTH`. Asserts `mem_req` with `mem_addr` = `fetch_addr`.
  - BUSY, `mem_ack` high:
    - Write `mem_rdata` into the buffer.
    - `fetch_addr` += 1.
    - Go to IDLE, or stay in BUSY with `mem_addr` = new `fetch_addr` if occupancy after the write and any pop is < `DEPTH`.
  - BUSY, `jump` without `mem_ack` → DISCARD.
  - DISCARD: hold `mem_req` and the old `mem_addr` until `mem_ack`, drop the returned data, then → BUSY at `fetch_addr` (= jump target).
- `mem_req` and `mem_addr` must stay stable from assertion until `mem_ack` is sampled; they are never withdrawn.
- Pop: `pcc & ir_valid & ~jump` removes the head and sets `pc` += 1.
- `pcc` with `ir_valid` = 0 is ignored (the CU sees `stall`). There is no bypass from `mem_rdata` to `ir_data`.
- `jump` has highest priority:
  - Flushes the buffer and sets `pc` = `fetch_addr` = `jump_addr`.
  - Any same-cycle `pcc` or `mem_ack` data is discarded.
  - `jump` in IDLE or with `mem_ack` → BUSY at `jump_addr` next cycle.
- Simultaneous push and pop: occupancy is unchanged, and is legal when full.
- Arithmetic: `pc` and `fetch_addr` are ADDR_W-bit modulo; `{ADDR_W{1'b1}}` + 1 = 0.
- An unsolicited `mem_ack` (IDLE) is ignored.

## Timing
- All outputs are registered except `stall`.
- First `mem_req` goes high after the first rising edge following reset deassertion.
- Memory latency: `mem_ack` is sampled at the earliest one edge after `mem_req` rises; it may take any number of cycles.
- Fill: data acked at edge E is in the buffer, with `ir_valid` high if the buffer was empty, from E.
- Redirect, zero-wait memory: `jump` at edge E0 gives `mem_req`(target) from E0, `mem_ack` at E1, and `ir_valid` with the target byte from E1.
- Zero-wait memory sustains one byte per cycle after 1 cycle of start-up; buffer never drains with `pcc` every cycle.
- Reset mid-transaction: everything returns to reset values immediately. Memory must drop the pending transaction on `reset`.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` (IDLE, BUSY, DISCARD).
  - Default `ADDR_W`, `DEPTH`, `RESET_PC` constants.
- Sub-module `fetch_fifo`:
  - `DEPTH`×8 circular buffer with push, pop, synchronous flush, count, full, empty.
  - Flush has priority over push and pop.
- Top level: FSM, `pc`/`fetch_addr` registers, and the memory handshake.

## Test plan
- Reset, zero-wait memory returning `addr[7:0]`, `pcc` every cycle after `ir_valid` → `ir_data` sequence 00,01,02…, `pc` 0,1,2…, `stall` never high.
- Memory with 3-cycle ack, `pcc` held high → `stall` high during gaps; no byte lost or duplicated; `mem_addr` stable while `mem_req` is waiting.
- `jump` to 0x1234 while a request to 0x0005 is pending → the 0x0005 data is dropped; next `mem_addr` = 0x1234; first `ir_data` = 0x34 with `pc` = 0x1234.
- `jump`, `pcc` and `mem_ack` in the same cycle → buffer flushed, `pc` = `jump_addr`, no pop and no push recorded.
- `jump` to 0xFFFE, consume 3 bytes → `pc` 0xFFFE, 0xFFFF, 0x0000; `mem_addr` wraps to 0x0000.
- No `pcc` for 10 cycles → exactly `DEPTH` acks, then `mem_req` low; one `pcc` → exactly one new request.
